// File: rtl/banco_registradores.sv
// Register bank with two combinational read ports, one write port and per-register pending bits.
// Reads zero-cycle; write/reserve act at the rising edge; no backpressure (always accepts).
module banco_registradores #(
    parameter int LARGURA  = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDRW    = $clog2(NUM_REGS),
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDRW-1:0]   RegLido1,
    input  logic [ADDRW-1:0]   RegLido2,
    input  logic [ADDRW-1:0]   RegEsc,
    input  logic               EscReg,
    input  logic [LARGURA-1:0] DadoEscr,
    input  logic               Reserva,
    input  logic [ADDRW-1:0]   RegReserva,
    output logic [LARGURA-1:0] Dado1,
    output logic [LARGURA-1:0] Dado2,
    output logic               Pendente1,
    output logic               Pendente2,
    output logic [ADDRW:0]     TotalPendentes
);

    localparam int CW = ADDRW + 1;
    localparam logic [ADDRW:0] LIMITE = CW'(NUM_REGS);

    logic [LARGURA-1:0]  regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [ADDRW:0]      total_next;
    logic                esc_ok;
    logic                res_ok;

    // A write or reserve is legal only inside the bank and never on a hardwired r0.
    assign esc_ok = EscReg && ({1'b0, RegEsc} < LIMITE)
                    && !((ZERO_R0 != 0) && (RegEsc == '0));
    assign res_ok = Reserva && ({1'b0, RegReserva} < LIMITE)
                    && !((ZERO_R0 != 0) && (RegReserva == '0));

    // Reserve is applied after the write so a newer producer keeps the register pending.
    always_comb begin
        pend_next = pend;
        if (esc_ok) pend_next[RegEsc] = 1'b0;
        if (res_ok) pend_next[RegReserva] = 1'b1;
    end

    always_comb begin
        total_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            total_next = total_next + CW'(pend_next[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pend           <= '0;
            TotalPendentes <= '0;
        end else begin
            if (esc_ok) regs[RegEsc] <= DadoEscr;
            pend           <= pend_next;
            TotalPendentes <= total_next;
        end
    end

    logic [ADDRW-1:0]   rd_addr [2];
    logic [LARGURA-1:0] rd_dat  [2];
    logic               rd_pend [2];

    assign rd_addr[0] = RegLido1;
    assign rd_addr[1] = RegLido2;

    for (genvar p = 0; p < 2; p++) begin : g_leitura
        logic em_faixa;
        logic zero_hit;
        logic fwd;

        assign em_faixa = ({1'b0, rd_addr[p]} < LIMITE);
        assign zero_hit = (ZERO_R0 != 0) && (rd_addr[p] == '0);
        assign fwd      = (BYPASS != 0) && esc_ok && (RegEsc == rd_addr[p]);

        // Forwarded data is the value the register is about to take, so it is never pending.
        always_comb begin
            rd_dat[p]  = '0;
            rd_pend[p] = 1'b0;
            if (fwd) begin
                rd_dat[p] = DadoEscr;
            end else if (em_faixa && !zero_hit) begin
                rd_dat[p]  = regs[rd_addr[p]];
                rd_pend[p] = pend[rd_addr[p]];
            end
        end
    end

    assign Dado1     = rd_dat[0];
    assign Dado2     = rd_dat[1];
    assign Pendente1 = rd_pend[0];
    assign Pendente2 = rd_pend[1];

endmodule
